mem_arbiter: RTL and testbench

Three-port arbiter and access sequencer that shares the single `basic_ram` instance between the boot loader, the core's data port and the core's instruction-fetch port. It grants one requester at a time and drives the RAM's `cs`/`we`/`oe`/address/data strobes for that requester. It waits for `mem_done`, then returns a one-cycle acknowledge, plus captured read data, to the granted port. A watchdog counter terminates accesses for which the RAM never signals `mem_done`.

---
 rtl/mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between loader, data and fetch ports.
// Grants one requester at a time, sequences the RAM strobes, returns a
// one-cycle ack (with err on watchdog expiry) and registered read data.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic        dm_req,
  input  logic        if_req,
  input  logic        ld_we,
  input  logic        dm_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] if_addr,
  input  logic [31:0] ld_wdata,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic [31:0] if_rdata,
  output logic        ld_ack,
  output logic        dm_ack,
  output logic        if_ack,
  output logic        ld_err,
  output logic        dm_err,
  output logic        if_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [1:0]  grant
);

  localparam int unsigned DW  = 32;
  localparam int unsigned WDW = 8;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LD   = 2'd1;
  localparam logic [1:0] G_DM   = 2'd2;
  localparam logic [1:0] G_IF   = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            rr_q, rr_d;           // 0: data port wins next tie, 1: fetch
  logic [WDW-1:0]  wd_q, wd_d;
  logic            mem_cs_q, mem_cs_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_oe_q, mem_oe_d;
  logic [DW-1:0]   mem_address_q, mem_address_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            ld_ack_q, ld_ack_d, dm_ack_q, dm_ack_d, if_ack_q, if_ack_d;
  logic            ld_err_q, ld_err_d, dm_err_q, dm_err_d, if_err_q, if_err_d;

  logic [1:0]      sel;
  logic            fin;
  logic            fin_err;
  logic [DW-1:0]   rd_val;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= G_NONE;
      rr_q          <= 1'b0;
      wd_q          <= '0;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_oe_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      dm_rdata_q    <= '0;
      if_rdata_q    <= '0;
      ld_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      if_ack_q      <= 1'b0;
      ld_err_q      <= 1'b0;
      dm_err_q      <= 1'b0;
      if_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      wd_q          <= wd_d;
      mem_cs_q      <= mem_cs_d;
      mem_we_q      <= mem_we_d;
      mem_oe_q      <= mem_oe_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_rdata_q    <= if_rdata_d;
      ld_ack_q      <= ld_ack_d;
      dm_ack_q      <= dm_ack_d;
      if_ack_q      <= if_ack_d;
      ld_err_q      <= ld_err_d;
      dm_err_q      <= dm_err_d;
      if_err_q      <= if_err_d;
    end
  end

  // Arbitration, access sequencing and completion decode
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    wd_d          = wd_q;
    mem_cs_d      = mem_cs_q;
    mem_we_d      = mem_we_q;
    mem_oe_d      = mem_oe_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_rdata_d    = if_rdata_q;
    ld_ack_d      = 1'b0;
    dm_ack_d      = 1'b0;
    if_ack_d      = 1'b0;
    ld_err_d      = 1'b0;
    dm_err_d      = 1'b0;
    if_err_d      = 1'b0;
    sel           = G_NONE;
    fin           = 1'b0;
    fin_err       = 1'b0;
    rd_val        = '0;

    case (state_q)
      IDLE: begin
        if (ld_req) begin
          sel = G_LD;
        end else if (dm_req && if_req) begin
          sel  = rr_q ? G_IF : G_DM;
          rr_d = ~rr_q;
        end else if (dm_req) begin
          sel = G_DM;
        end else if (if_req) begin
          sel = G_IF;
        end

        if (sel != G_NONE) begin
          state_d  = ACCESS;
          grant_d  = sel;
          wd_d     = '0;
          mem_cs_d = 1'b1;
          case (sel)
            G_LD: begin
              mem_address_d = ld_addr;
              mem_wdata_d   = ld_wdata;
              mem_we_d      = ld_we;
            end
            G_DM: begin
              mem_address_d = dm_addr;
              mem_wdata_d   = dm_wdata;
              mem_we_d      = dm_we;
            end
            default: begin
              mem_address_d = if_addr;
              mem_we_d      = 1'b0;
            end
          endcase
          mem_oe_d = ~mem_we_d;
        end
      end
      ACCESS: begin
        if (!mem_done) wd_d = wd_q + WDW'(1);
        if (mem_done || (wd_q == WD_LAST)) begin
          fin     = 1'b1;
          fin_err = ~mem_done;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion: a read on timeout returns zero instead of RAM data
    if (fin) begin
      state_d  = RELEASE;
      grant_d  = G_NONE;
      mem_cs_d = 1'b0;
      mem_we_d = 1'b0;
      mem_oe_d = 1'b0;
      rd_val   = fin_err ? '0 : mem_rdata;
      case (grant_q)
        G_LD: begin
          ld_ack_d = 1'b1;
          ld_err_d = fin_err;
        end
        G_DM: begin
          dm_ack_d = 1'b1;
          dm_err_d = fin_err;
          if (!mem_we_q) dm_rdata_d = rd_val;
        end
        G_IF: begin
          if_ack_d = 1'b1;
          if_err_d = fin_err;
          if (!mem_we_q) if_rdata_d = rd_val;
        end
        default: ;
      endcase
    end
  end

  assign grant       = grant_q;
  assign mem_cs      = mem_cs_q;
  assign mem_we      = mem_we_q;
  assign mem_oe      = mem_oe_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_rdata    = if_rdata_q;
  assign ld_ack      = ld_ack_q;
  assign dm_ack      = dm_ack_q;
  assign if_ack      = if_ack_q;
  assign ld_err      = ld_err_q;
  assign dm_err      = dm_err_q;
  assign if_err      = if_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: RAM model with programmable wait states,
// scoreboard of expected completions checked at every ack.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_req = 0, dm_req = 0, if_req = 0;
  logic        ld_we = 0, dm_we = 0;
  logic [31:0] ld_addr = 0, dm_addr = 0, if_addr = 0;
  logic [31:0] ld_wdata = 0, dm_wdata = 0;
  logic [31:0] dm_rdata, if_rdata;
  logic        ld_ack, dm_ack, if_ack, ld_err, dm_err, if_err;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        mem_cs, mem_we, mem_oe;
  logic [1:0]  grant;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .dm_req(dm_req), .if_req(if_req),
    .ld_we(ld_we), .dm_we(dm_we),
    .ld_addr(ld_addr), .dm_addr(dm_addr), .if_addr(if_addr),
    .ld_wdata(ld_wdata), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .if_rdata(if_rdata),
    .ld_ack(ld_ack), .dm_ack(dm_ack), .if_ack(if_ack),
    .ld_err(ld_err), .dm_err(dm_err), .if_err(if_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // RAM model: done after ram_wait extra cycles of cs, or never when hung
  logic [31:0] ram [256];
  int          ram_cnt = 0;
  int          ram_wait = 0;
  logic        ram_hang = 0;
  logic        force_done = 0;

  assign mem_done  = force_done | (mem_cs & ~ram_hang & (ram_cnt == ram_wait));
  assign mem_rdata = ram[mem_address[7:0]];

  always @(posedge clk) begin
    if (mem_cs) ram_cnt <= ram_cnt + 1;
    else        ram_cnt <= 0;
    if (mem_cs && mem_done && mem_we) ram[mem_address[7:0]] <= mem_wdata;
  end

  // Scoreboard
  typedef struct {
    logic [1:0]  port;
    logic        err;
    logic [31:0] dm_exp;
    logic [31:0] if_exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] shadow [256];
  logic [31:0] exp_dm = 0, exp_if = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic void push_exp(input logic [1:0] port, input logic we,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic err);
    exp_t e;
    if (we && !err) shadow[addr[7:0]] = wdata;
    if (!we) begin
      if (port == 2'd2) exp_dm = err ? 32'h0 : shadow[addr[7:0]];
      if (port == 2'd3) exp_if = err ? 32'h0 : shadow[addr[7:0]];
    end
    e.port = port; e.err = err; e.dm_exp = exp_dm; e.if_exp = exp_if;
    sb_q.push_back(e);
  endfunction

  // Completion monitor: pop one expectation per ack
  exp_t       mon_e;
  logic [2:0] mon_vec;
  always @(negedge clk) begin
    if (!rst && (ld_ack | dm_ack | if_ack)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack acks=%b", {ld_ack, dm_ack, if_ack});
      end else begin
        mon_e   = sb_q.pop_front();
        mon_vec = (mon_e.port == 2'd1) ? 3'b100 : (mon_e.port == 2'd2) ? 3'b010 : 3'b001;
        if ({ld_ack, dm_ack, if_ack} !== mon_vec ||
            {ld_err, dm_err, if_err} !== (mon_e.err ? mon_vec : 3'b000) ||
            dm_rdata !== mon_e.dm_exp || if_rdata !== mon_e.if_exp) begin
          errors++;
          $display("FAIL completion ack=%b err=%b dm=%h if=%h expected ack=%b err=%b dm=%h if=%h",
                   {ld_ack, dm_ack, if_ack}, {ld_err, dm_err, if_err}, dm_rdata, if_rdata,
                   mon_vec, mon_e.err ? mon_vec : 3'b000, mon_e.dm_exp, mon_e.if_exp);
        end
      end
    end else if (!rst && (ld_err | dm_err | if_err)) begin
      checks++;
      errors++;
      $display("FAIL err_without_ack err=%b", {ld_err, dm_err, if_err});
    end
  end

  // Single access on one port; reports ack cycle index and cs activity
  task automatic do_access(input logic [1:0] port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int cycles, output int cs_cycles,
                           output bit bus_ok, output logic [1:0] gnt_seen);
    bit got;
    @(posedge clk); #1;
    case (port)
      2'd1: begin ld_req = 1; ld_we = we; ld_addr = addr; ld_wdata = wdata; end
      2'd2: begin dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
      default: begin if_req = 1; if_addr = addr; end
    endcase
    cycles = 0; cs_cycles = 0; bus_ok = 1; gnt_seen = 2'd0; got = 0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (mem_cs) begin
        cs_cycles++;
        gnt_seen = grant;
        if (mem_address !== addr || mem_we !== we || mem_oe !== !we ||
            (we && mem_wdata !== wdata)) bus_ok = 0;
      end
      if ((port == 2'd1 && ld_ack) || (port == 2'd2 && dm_ack) || (port == 2'd3 && if_ack))
        got = 1;
      else
        cycles++;
    end
    ld_req = 0; dm_req = 0; if_req = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL access_timeout port=%0d no ack within bound", port);
    end
  endtask

  task automatic test_reset();
    int cs_seen;
    rst = 1;
    @(negedge clk);
    checks++;
    if ({grant, mem_cs, mem_we, mem_oe, ld_ack, dm_ack, if_ack, ld_err, dm_err, if_err} !== 12'h0) begin
      errors++; $display("FAIL reset_ctrl got=%h expected=0",
        {grant, mem_cs, mem_we, mem_oe, ld_ack, dm_ack, if_ack, ld_err, dm_err, if_err});
    end
    checks++;
    if ({mem_address, mem_wdata, dm_rdata, if_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data addr=%h wdata=%h dm=%h if=%h expected all 0",
                         mem_address, mem_wdata, dm_rdata, if_rdata);
    end
    @(posedge clk); #1; rst = 0;
    cs_seen = 0;
    repeat (10) begin @(negedge clk); if (mem_cs) cs_seen++; end
    checks++;
    if (cs_seen !== 0) begin errors++; $display("FAIL idle_cs got=%0d expected=0", cs_seen); end
    // Async reset in the middle of a hung access
    ram_hang = 1;
    @(posedge clk); #1; dm_req = 1; dm_we = 0; dm_addr = 32'd3;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_cs !== 1'b1) begin errors++; $display("FAIL pre_reset_cs got=%b expected=1", mem_cs); end
    #2 rst = 1;
    #1;
    checks++;
    if ({mem_cs, grant} !== 3'b000 || mem_address !== 32'h0) begin
      errors++; $display("FAIL async_reset cs=%b grant=%0d addr=%h expected 0", mem_cs, grant, mem_address);
    end
    dm_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; ram_hang = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_loader_write();
    int cyc, csc; bit ok; logic [1:0] g;
    ram_wait = 3;
    push_exp(2'd1, 1'b1, 32'd5, 32'hE3A0_1001, 1'b0);
    do_access(2'd1, 1'b1, 32'd5, 32'hE3A0_1001, cyc, csc, ok, g);
    checks++;
    if (csc !== 4 || !ok || g !== 2'd1) begin
      errors++; $display("FAIL ld_write cs_cycles=%0d bus_ok=%0d grant=%0d expected 4 1 1", csc, ok, g);
    end
    @(negedge clk);
    checks++;
    if (ld_ack !== 1'b0) begin errors++; $display("FAIL ld_ack_pulse got=%b expected=0", ld_ack); end
  endtask

  task automatic test_fetch_read();
    int cyc, csc; bit ok; logic [1:0] g;
    ram_wait = 0;
    push_exp(2'd3, 1'b0, 32'd5, 32'h0, 1'b0);
    do_access(2'd3, 1'b0, 32'd5, 32'h0, cyc, csc, ok, g);
    checks++;
    if (if_rdata !== 32'hE3A0_1001 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL if_read if=%h dm=%h expected E3A01001 00000000", if_rdata, dm_rdata);
    end
    checks++;
    if (cyc !== 2 || csc !== 1 || !ok || g !== 2'd3) begin
      errors++; $display("FAIL if_latency cycles=%0d cs=%0d ok=%0d grant=%0d expected 2 1 1 3", cyc, csc, ok, g);
    end
    // Data write then read back on the data port; fetch data must hold
    ram_wait = 1;
    push_exp(2'd2, 1'b1, 32'd9, 32'h1234_5678, 1'b0);
    do_access(2'd2, 1'b1, 32'd9, 32'h1234_5678, cyc, csc, ok, g);
    push_exp(2'd2, 1'b0, 32'd9, 32'h0, 1'b0);
    do_access(2'd2, 1'b0, 32'd9, 32'h0, cyc, csc, ok, g);
    checks++;
    if (dm_rdata !== 32'h1234_5678 || if_rdata !== 32'hE3A0_1001 || cyc !== 3) begin
      errors++; $display("FAIL dm_rw dm=%h if=%h cycles=%0d expected 12345678 E3A01001 3", dm_rdata, if_rdata, cyc);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [$];
    logic [1:0] want [8] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};
    logic prev_cs;
    int k;
    ram_wait = 0;
    for (int r = 0; r < 2; r++) begin
      push_exp(2'd2, 1'b0, 32'd22, 32'h0, 1'b0);
      if (r == 1) push_exp(2'd1, 1'b0, 32'd30, 32'h0, 1'b0);
      push_exp(2'd3, 1'b0, 32'd23, 32'h0, 1'b0);
      if (r == 0) push_exp(2'd2, 1'b0, 32'd22, 32'h0, 1'b0);
      if (r == 0) push_exp(2'd3, 1'b0, 32'd23, 32'h0, 1'b0);
      else        push_exp(2'd2, 1'b0, 32'd22, 32'h0, 1'b0);
      @(posedge clk); #1;
      dm_req = 1; dm_we = 0; dm_addr = 32'd22; if_req = 1; if_addr = 32'd23;
      k = 0; prev_cs = 0;
      for (int n = 0; n < 200 && k < 4; n++) begin
        @(negedge clk);
        if (mem_cs && !prev_cs) seq.push_back(grant);
        prev_cs = mem_cs;
        if (ld_ack) ld_req = 0;
        if (ld_ack | dm_ack | if_ack) begin
          k++;
          if (r == 1 && k == 1) begin ld_req = 1; ld_we = 0; ld_addr = 32'd30; end
        end
      end
      dm_req = 0; if_req = 0; ld_req = 0;
      checks++;
      if (k !== 4) begin errors++; $display("FAIL rr_count round=%0d got=%0d expected=4", r, k); end
    end
    checks++;
    if (seq.size() !== 8) begin
      errors++; $display("FAIL rr_len got=%0d expected=8", seq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (seq[i] !== want[i]) begin
          errors++; $display("FAIL rr_order idx=%0d got=%0d expected=%0d", i, seq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, csc; bit ok; logic [1:0] g;
    ram_hang = 1;
    push_exp(2'd2, 1'b0, 32'd40, 32'h0, 1'b1);
    do_access(2'd2, 1'b0, 32'd40, 32'h0, cyc, csc, ok, g);
    checks++;
    if (csc !== TIMEOUT || cyc !== TIMEOUT + 1 || dm_err !== 1'b1 || dm_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout cs=%0d ack_cycle=%0d err=%b dm=%h expected %0d %0d 1 0",
                         csc, cyc, dm_err, dm_rdata, TIMEOUT, TIMEOUT + 1);
    end
    @(negedge clk);
    checks++;
    if ({dm_ack, dm_err} !== 2'b00) begin errors++; $display("FAIL timeout_pulse got=%b expected=00", {dm_ack, dm_err}); end
    ram_hang = 0; ram_wait = 2;
    push_exp(2'd2, 1'b0, 32'd41, 32'h0, 1'b0);
    do_access(2'd2, 1'b0, 32'd41, 32'h0, cyc, csc, ok, g);
    checks++;
    if (csc !== 3 || dm_rdata !== 32'hC0DE_0029) begin
      errors++; $display("FAIL post_timeout cs=%0d dm=%h expected 3 C0DE0029", csc, dm_rdata);
    end
  endtask

  task automatic test_collision();
    int cyc, csc; bit ok; logic [1:0] g;
    ram_wait = TIMEOUT - 1;
    push_exp(2'd3, 1'b0, 32'd50, 32'h0, 1'b0);
    do_access(2'd3, 1'b0, 32'd50, 32'h0, cyc, csc, ok, g);
    checks++;
    if (csc !== TIMEOUT || if_err !== 1'b0 || if_rdata !== 32'hC0DE_0032) begin
      errors++; $display("FAIL collision cs=%0d err=%b if=%h expected %0d 0 C0DE0032",
                         csc, if_err, if_rdata, TIMEOUT);
    end
  endtask

  task automatic test_stray_done();
    int cs_seen = 0;
    @(posedge clk); #1 force_done = 1;
    repeat (4) begin @(negedge clk); if (mem_cs | ld_ack | dm_ack | if_ack) cs_seen++; end
    force_done = 0;
    checks++;
    if (cs_seen !== 0) begin errors++; $display("FAIL stray_done activity=%0d expected=0", cs_seen); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'hC0DE_0000 | 32'(i);
      shadow[i] = 32'hC0DE_0000 | 32'(i);
    end
    test_reset();
    test_loader_write();
    test_fetch_read();
    test_round_robin();
    test_timeout();
    test_collision();
    test_stray_done();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL sb_drain pending=%0d expected=0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
